// File: rtl/phys_free_list.sv
// Physical register free list: circular FIFO of free preg indices, two retire frees and one allocation per cycle.
// Optional duplicate-free detection with an in-list bitmap is enabled by defining FREE_LIST_DUP_CHECK_EN.
`ifndef RETIRE_WIDTH
`define RETIRE_WIDTH 45
`endif

module phys_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_ARCH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_en,
  output logic [5:0]               alloc_preg,
  output logic                     alloc_ok,
  input  logic [`RETIRE_WIDTH-1:0] retire0,
  input  logic [`RETIRE_WIDTH-1:0] retire1,
  output logic [6:0]               free_count,
  output logic                     err
);

  localparam int          W       = `RETIRE_WIDTH;
  localparam int          IW      = $clog2(NUM_PREGS);
  localparam logic [6:0]  CNT_MAX = 7'(NUM_PREGS);
  localparam logic [6:0]  CNT_RST = 7'(NUM_PREGS - NUM_ARCH);
  localparam logic [IW-1:0] TAIL_RST = IW'((NUM_PREGS - NUM_ARCH) % NUM_PREGS);

  logic [5:0]    r_mem [NUM_PREGS];
  logic [IW-1:0] r_head;
  logic [IW-1:0] r_tail;
  logic [6:0]    r_count;
  logic          r_err;

  logic          w_v0, w_v1;
  logic [5:0]    w_rd0, w_rd1;
  logic          w_unused_fields;
  logic          w_pop, w_req0, w_req1, w_push0, w_push1;
  logic          w_dup0, w_dup1;
  logic [6:0]    w_cnt_pop, w_cnt0, w_cnt_nxt;
  logic [IW-1:0] w_wr1_ptr, w_tail_nxt, w_head_nxt;
  logic          w_err_nxt;
`ifdef FREE_LIST_DUP_CHECK_EN
  logic [NUM_PREGS-1:0] r_map;
  logic [NUM_PREGS-1:0] w_map_pop, w_map0, w_map_nxt;
`endif

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(NUM_PREGS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Retire slot format is {valid, rd_old, data, rd}; only valid and rd_old matter here.
  assign w_v0  = retire0[W-1];
  assign w_v1  = retire1[W-1];
  assign w_rd0 = retire0[W-2 -: 6];
  assign w_rd1 = retire1[W-2 -: 6];
  assign w_unused_fields = ^{retire0[W-8:0], retire1[W-8:0]};

  assign alloc_preg = r_mem[r_head];
  assign alloc_ok   = (r_count != 7'd0);
  assign free_count = r_count;
  assign err        = r_err;

  always_comb begin
    w_pop     = alloc_en & alloc_ok;
    w_req0    = w_v0 & (w_rd0 != 6'd0);
    w_req1    = w_v1 & (w_rd1 != 6'd0);
    w_cnt_pop = r_count - {6'd0, w_pop};
`ifdef FREE_LIST_DUP_CHECK_EN
    // The preg leaving the head this cycle no longer counts as in the list.
    w_map_pop = r_map;
    if (w_pop) w_map_pop[alloc_preg] = 1'b0;
    w_dup0 = w_map_pop[w_rd0];
`else
    w_dup0 = 1'b0;
`endif
    w_push0 = w_req0 & (w_cnt_pop < CNT_MAX) & ~w_dup0;
    w_cnt0  = w_cnt_pop + {6'd0, w_push0};
`ifdef FREE_LIST_DUP_CHECK_EN
    w_map0 = w_map_pop;
    if (w_push0) w_map0[w_rd0] = 1'b1;
    w_dup1 = w_map0[w_rd1];
`else
    w_dup1 = 1'b0;
`endif
    w_push1   = w_req1 & (w_cnt0 < CNT_MAX) & ~w_dup1;
    w_cnt_nxt = w_cnt0 + {6'd0, w_push1};
`ifdef FREE_LIST_DUP_CHECK_EN
    w_map_nxt = w_map0;
    if (w_push1) w_map_nxt[w_rd1] = 1'b1;
`endif
    w_wr1_ptr  = w_push0 ? ptr_inc(r_tail) : r_tail;
    w_tail_nxt = w_push1 ? ptr_inc(w_wr1_ptr) : w_wr1_ptr;
    w_head_nxt = w_pop ? ptr_inc(r_head) : r_head;
    w_err_nxt  = r_err | (alloc_en & ~alloc_ok) | (w_req0 & ~w_push0) | (w_req1 & ~w_push1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++)
        r_mem[i] <= (i < NUM_PREGS - NUM_ARCH) ? 6'(NUM_ARCH + i) : 6'd0;
    end else begin
      if (w_push0) r_mem[r_tail] <= w_rd0;
      if (w_push1) r_mem[w_wr1_ptr] <= w_rd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= TAIL_RST;
      r_count <= CNT_RST;
      r_err   <= 1'b0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++)
        r_map[i] <= (i >= NUM_ARCH);
    end else begin
      r_map <= w_map_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Randomized bench for phys_free_list with a queue-based reference model and directed literal checks.
`ifndef RETIRE_WIDTH
`define RETIRE_WIDTH 45
`endif

module tb_phys_free_list;
  localparam int W = `RETIRE_WIDTH;
  localparam int NP = 64;
  localparam int NA = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         alloc_en;
  logic [5:0]   alloc_preg;
  logic         alloc_ok;
  logic [W-1:0] retire0, retire1;
  logic [6:0]   free_count;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  int q[$];
  bit m_err;

  phys_free_list #(.NUM_PREGS(NP), .NUM_ARCH(NA)) dut (
    .clk(clk), .rst(rst), .alloc_en(alloc_en), .alloc_preg(alloc_preg),
    .alloc_ok(alloc_ok), .retire0(retire0), .retire1(retire1),
    .free_count(free_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input bit v, input int r);
    logic [W-1:0] w;
    w = W'({$urandom(), $urandom()});
    w[W-1] = v;
    w[W-2 -: 6] = 6'(r);
    return w;
  endfunction

  function automatic void model_reset();
    q.delete();
    for (int i = NA; i < NP; i++) q.push_back(i);
    m_err = 1'b0;
  endfunction

  function automatic bit in_list(input int r);
    foreach (q[i]) if (q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_free(input bit v, input int r);
    if (!v || r == 0) return;
    if (q.size() >= NP) begin
      m_err = 1'b1;
      return;
    end
`ifdef FREE_LIST_DUP_CHECK_EN
    if (in_list(r)) begin
      m_err = 1'b1;
      return;
    end
`endif
    q.push_back(r);
  endfunction

  // One clock edge of the list: pop first, then slot 0, then slot 1.
  function automatic void model_step();
    if (alloc_en) begin
      if (q.size() != 0) void'(q.pop_front());
      else m_err = 1'b1;
    end
    model_free(retire0[W-1], int'(retire0[W-2 -: 6]));
    model_free(retire1[W-1], int'(retire1[W-2 -: 6]));
  endfunction

  always @(negedge clk) begin
    chk("alloc_ok", int'(alloc_ok), int'(q.size() != 0));
    chk("free_count", int'(free_count), q.size());
    chk("err", int'(err), int'(m_err));
    if (q.size() != 0) chk("alloc_preg", int'(alloc_preg), q[0]);
  end

  task automatic step(input bit a, input bit v0, input int r0, input bit v1, input int r1);
    alloc_en = a;
    retire0  = mk(v0, r0);
    retire1  = mk(v1, r1);
    @(posedge clk);
    model_step();
    #1;
    alloc_en = 1'b0;
    retire0  = mk(1'b0, 0);
    retire1  = mk(1'b0, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_alloc_ok"}, int'(alloc_ok), 1);
    chk({tag, "_alloc_preg"}, int'(alloc_preg), NA);
    chk({tag, "_free_count"}, int'(free_count), NP - NA);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  // Called just after an edge: asserts rst between edges with live inputs that must be discarded.
  task automatic mid_reset();
    #2;
    alloc_en = 1'b1;
    retire0  = mk(1'b1, 5);
    retire1  = mk(1'b1, 9);
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_vals("rst_now");
    @(posedge clk);
    #1;
    check_reset_vals("rst_held");
    #2;
    rst = 1'b0;
    alloc_en = 1'b0;
    retire0  = mk(1'b0, 0);
    retire1  = mk(1'b0, 0);
  endtask

  initial begin
    int pct;
    rst = 1'b1;
    alloc_en = 1'b0;
    retire0 = '0;
    retire1 = '0;
    model_reset();
    #1;
    check_reset_vals("por");
    #21;
    rst = 1'b0;
    #1;
    check_reset_vals("post_rst");

    for (int i = 0; i < 32; i++) begin
      chk("drain_preg", int'(alloc_preg), 32 + i);
      step(1'b1, 1'b0, 0, 1'b0, 0);
    end
    chk("drained_count", int'(free_count), 0);
    chk("drained_ok", int'(alloc_ok), 0);
    chk("drained_err", int'(err), 0);

    chk("empty_ok_same_cycle", int'(alloc_ok), 0);
    step(1'b0, 1'b1, 40, 1'b0, 0);
    chk("free40_ok", int'(alloc_ok), 1);
    chk("free40_preg", int'(alloc_preg), 40);
    chk("free40_count", int'(free_count), 1);

    step(1'b1, 1'b1, 5, 1'b1, 9);
    chk("dual_count", int'(free_count), 2);
    chk("dual_head0", int'(alloc_preg), 5);
    step(1'b1, 1'b0, 0, 1'b0, 0);
    chk("dual_head1", int'(alloc_preg), 9);
    step(1'b1, 1'b0, 0, 1'b0, 0);
    chk("dual_drained", int'(free_count), 0);

    step(1'b0, 1'b1, 0, 1'b0, 0);
    chk("free0_count", int'(free_count), 0);
    chk("free0_err", int'(err), 0);

    step(1'b0, 1'b1, 50, 1'b0, 0);
    step(1'b0, 1'b1, 50, 1'b0, 0);
`ifdef FREE_LIST_DUP_CHECK_EN
    chk("dup50_count", int'(free_count), 1);
    chk("dup50_err", int'(err), 1);
`else
    chk("dup50_count", int'(free_count), 2);
    chk("dup50_err", int'(err), 0);
`endif
    mid_reset();

    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 2*k + 1, 1'b1, 2*k + 2);
`ifndef FREE_LIST_DUP_CHECK_EN
    chk("fill_count", int'(free_count), 64);
    chk("fill_err", int'(err), 0);
    step(1'b0, 1'b1, 7, 1'b1, 8);
    chk("full_dual_count", int'(free_count), 64);
    chk("full_dual_err", int'(err), 1);
`endif
    step(1'b1, 1'b1, 11, 1'b1, 12);

    step(1'b1, 1'b1, 3, 1'b0, 0);
    mid_reset();
    for (int i = 0; i < 64; i++) step(1'b1, 1'b1, q[0], 1'b0, 0);
    chk("wrap_preg", int'(alloc_preg), 32);
    chk("wrap_count", int'(free_count), 32);
    chk("wrap_err", int'(err), 0);

    pct = 40;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) pct = $urandom_range(5, 75);
      step($urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < pct, $urandom_range(0, 63),
           $urandom_range(0, 99) < pct, $urandom_range(0, 63));
      if ($urandom_range(0, 299) == 0) mid_reset();
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/phys_free_list.md
PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 Parameter NUM_PREGS, default 64: number of physical registers; the preg index is 6 bits.
REQ-002 Parameter NUM_ARCH, default 32: pregs 0..NUM_ARCH-1 are architecturally mapped at reset.
REQ-003 Port clk, input, 1: the single clock; all state updates on posedge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port alloc_en, input, 1: rename stage consumes alloc_preg this cycle.
REQ-006 Port alloc_preg, output, 6: preg at the list head, combinational from the head entry.
REQ-007 Port alloc_ok, output, 1: list non-empty, so alloc_preg is valid.
REQ-008 Port retire0, input, `RETIRE_WIDTH: ROB retire slot 0, formatted {valid, rd_old, data, rd}.
REQ-009 Port retire1, input, `RETIRE_WIDTH: ROB retire slot 1, same format as retire0.
REQ-010 Port free_count, output, 7: number of entries currently free.
REQ-011 Port err, output, 1: sticky error flag; cleared only by rst.

Function
REQ-012 Storage: circular FIFO of NUM_PREGS 6-bit entries, with head and tail pointers that wrap modulo NUM_PREGS.
REQ-013 Free source: a slot frees its rd_old field when that slot's valid bit (MSB) is 1.
REQ-014 Freeing preg 0 is ignored: no push, no error.
REQ-015 Per-cycle push order: slot 0 first, then slot 1, so 0, 1 or 2 pushes per cycle.
REQ-016 Pop: on posedge with alloc_en=1 and alloc_ok=1, head advances by 1.
REQ-017 alloc_en while alloc_ok=0 is ignored and sets err.
REQ-018 Same-cycle bypass: none; pregs pushed in cycle N are allocatable from cycle N+1, even when the list is empty in cycle N.
REQ-019 Count update per posedge: free_count_next = free_count - pop + pushes.
REQ-020 Simultaneous pop and push are both legal, including at full and at empty.
REQ-021 Overflow: a push that would make the count exceed NUM_PREGS is dropped and sets err.
REQ-022 Overflow is evaluated after the same-cycle pop, with slot 0 accepted before slot 1.
REQ-023 alloc_ok = (free_count != 0).
REQ-024 alloc_preg holds the head entry value regardless of alloc_ok.

Reset
REQ-025 While rst=1, all state is held at its reset value, independent of clk.
REQ-026 Reset value of entries 0..NUM_PREGS-NUM_ARCH-1: NUM_ARCH..NUM_PREGS-1, in ascending order.
REQ-027 Reset value of head is 0.
REQ-028 Reset value of tail is NUM_PREGS-NUM_ARCH, modulo NUM_PREGS.
REQ-029 Reset value of free_count is NUM_PREGS-NUM_ARCH.
REQ-030 Reset values of the outputs: alloc_ok=1, alloc_preg=NUM_ARCH, err=0.
REQ-031 Reset asserted mid-operation discards all pending pops and pushes of that cycle.
REQ-032 After rst deasserts, the first posedge behaves as a normal cycle.

Configuration
REQ-033 Macro FREE_LIST_DUP_CHECK_EN, when defined: a NUM_PREGS-bit in-list bitmap is maintained.
REQ-034 With FREE_LIST_DUP_CHECK_EN, the bitmap bit is set on push and cleared on pop; its reset value marks the reset-time free pregs.
REQ-035 With FREE_LIST_DUP_CHECK_EN, a push of a preg already in the list is dropped and sets err.
REQ-036 With FREE_LIST_DUP_CHECK_EN, slot0 and slot1 carrying the same rd_old in one cycle push once and set err.
REQ-037 Without FREE_LIST_DUP_CHECK_EN: no bitmap, duplicates are pushed, and err comes from underflow/overflow only.

Verification
REQ-038 Reset, then 32 consecutive alloc_en -> alloc_preg reads 32..63 in order; free_count reaches 0; alloc_ok=0.
REQ-039 Empty list, retire0 valid with rd_old=40 -> alloc_ok=0 that cycle; next cycle alloc_ok=1, alloc_preg=40, free_count=1.
REQ-040 Frees 5 on slot 0 and 9 on slot 1, with alloc_en, in the same cycle -> next cycle free_count = prev+1, and the tail order is 5 then 9.
REQ-041 retire0 valid with rd_old=0 -> free_count unchanged, err=0.
REQ-042 With FREE_LIST_DUP_CHECK_EN, free 50 while 50 is still in the list -> push dropped, err=1.
REQ-043 Without FREE_LIST_DUP_CHECK_EN, the same stimulus -> count+1.
REQ-044 Full list with a dual free -> both pushes dropped and err=1.
REQ-045 rst pulsed mid-stream between clock edges -> state returns immediately to the REQ-026..REQ-030 values.
REQ-046 After that mid-stream reset, the head wraps correctly after 64 pop/push pairs.
